// File: rtl/seq_divider_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seq_divider_pkg                                             |
// | Brief  : FSM state encoding and counter-width helper for seq_divider |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package seq_divider_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    typedef enum logic [1:0] {
        IDLE = c_st_idle,
        BUSY = c_st_busy,
        DONE = c_st_done
    } state_t;

    // Bits needed to count down from value-1 to 0; never less than one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seq_divider_div_step                                        |
// | Brief  : One restoring-division step: shift in a bit, trial subtract |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module seq_divider_div_step #(
    parameter int DENOM_W = 4
) (
    input  logic [DENOM_W-1:0] rem_in,
    input  logic               numer_bit,
    input  logic [DENOM_W-1:0] denom,
    output logic [DENOM_W-1:0] rem_out,
    output logic               q_bit
);

    logic [DENOM_W:0]   w_shift;
    logic [DENOM_W-1:0] w_diff;

    assign w_shift = {rem_in, numer_bit};
    assign q_bit   = (w_shift >= {1'b0, denom});
    // When the subtract happens the true difference is below denom, so the
    // low DENOM_W bits of a narrow subtract are exact.
    assign w_diff  = w_shift[DENOM_W-1:0] - denom;
    assign rem_out = q_bit ? w_diff : w_shift[DENOM_W-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : seq_divider                                                 |
// | Brief  : Iterative unsigned restoring divider, one bit per clock     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int NUMER_W = 6,
    parameter int DENOM_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NUMER_W-1:0] numer,
    input  logic [DENOM_W-1:0] denom,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUMER_W-1:0] quotient,
    output logic [DENOM_W-1:0] remain,
    output logic               div_by_zero
);

    localparam int               CNT_W      = clog2(NUMER_W);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(NUMER_W - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [NUMER_W-1:0] r_work;
    logic [DENOM_W-1:0] r_denom;
    logic [DENOM_W-1:0] r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic [DENOM_W-1:0] w_rem_next;
    logic               w_q_bit;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    seq_divider_div_step #(
        .DENOM_W (DENOM_W)
    ) u_div_step (
        .rem_in    (r_rem),
        .numer_bit (r_work[NUMER_W-1]),
        .denom     (r_denom),
        .rem_out   (w_rem_next),
        .q_bit     (w_q_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = (denom == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // r_work shifts the dividend out of its MSB while quotient bits enter at
    // the LSB, so after NUMER_W steps it holds the full quotient.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work      <= '0;
            r_denom     <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            quotient    <= '0;
            remain      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work  <= numer;
                        r_denom <= denom;
                        r_rem   <= '0;
                        r_cnt   <= c_cnt_last;
                        if (denom == '0) begin
                            quotient    <= '1;
                            remain      <= numer[DENOM_W-1:0];
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    r_work <= {r_work[NUMER_W-2:0], w_q_bit};
                    r_rem  <= w_rem_next;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        quotient    <= {r_work[NUMER_W-2:0], w_q_bit};
                        remain      <= w_rem_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_seq_divider                                              |
// | Brief  : Self-checking bench for seq_divider, 6/4 and 16/8 widths    |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_seq_divider;

    localparam int S_NW = 6;
    localparam int S_DW = 4;
    localparam int W_NW = 16;
    localparam int W_DW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic            s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0, s_dbz;
    logic [S_NW-1:0] s_numer = '0, s_quotient;
    logic [S_DW-1:0] s_denom = '0, s_remain;

    logic            w_in_valid = 1'b0, w_in_ready, w_out_valid, w_out_ready = 1'b0, w_dbz;
    logic [W_NW-1:0] w_numer = '0, w_quotient;
    logic [W_DW-1:0] w_denom = '0, w_remain;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_divider #(.NUMER_W(S_NW), .DENOM_W(S_DW)) dut_s (
        .clk (clk), .reset (reset),
        .in_valid (s_in_valid), .in_ready (s_in_ready),
        .numer (s_numer), .denom (s_denom),
        .out_valid (s_out_valid), .out_ready (s_out_ready),
        .quotient (s_quotient), .remain (s_remain), .div_by_zero (s_dbz)
    );

    seq_divider #(.NUMER_W(W_NW), .DENOM_W(W_DW)) dut_w (
        .clk (clk), .reset (reset),
        .in_valid (w_in_valid), .in_ready (w_in_ready),
        .numer (w_numer), .denom (w_denom),
        .out_valid (w_out_valid), .out_ready (w_out_ready),
        .quotient (w_quotient), .remain (w_remain), .div_by_zero (w_dbz)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair to the small instance; returns after the acceptance edge.
    task automatic small_start(input logic [S_NW-1:0] n, input logic [S_DW-1:0] d);
        int guard = 0;
        while (s_in_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        s_in_valid = 1'b1;
        s_numer    = n;
        s_denom    = d;
        tick();
        s_in_valid = 1'b0;
    endtask

    // Cycles after the acceptance edge until out_valid; 99 means it never came.
    task automatic small_wait(output int lat);
        lat = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (s_out_valid === 1'b1) return;
        end
        lat = 99;
    endtask

    task automatic small_release();
        s_out_ready = 1'b1;
        tick();
        s_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks += 6;
        if (s_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", s_in_ready); end
        if (s_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", s_out_valid); end
        if (s_quotient !== '0) begin failures++; $display("FAIL reset_quotient got=%0d exp=0", s_quotient); end
        if (s_remain !== '0) begin failures++; $display("FAIL reset_remain got=%0d exp=0", s_remain); end
        if (s_dbz !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", s_dbz); end
        if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_wide got ready=%b valid=%b exp 1/0", w_in_ready, w_out_valid);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        int exp_q = 45 / 12;
        int exp_r = 45 % 12;
        small_start(6'd45, 4'd12);
        small_wait(lat);
        checks += 4;
        if (lat != S_NW) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, S_NW); end
        if (s_quotient !== S_NW'(exp_q)) begin failures++; $display("FAIL basic_quotient got=%0d exp=%0d", s_quotient, exp_q); end
        if (s_remain !== S_DW'(exp_r)) begin failures++; $display("FAIL basic_remain got=%0d exp=%0d", s_remain, exp_r); end
        if (s_dbz !== 1'b0) begin failures++; $display("FAIL basic_dbz got=%b exp=0", s_dbz); end
        small_release();
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            failures++; $display("FAIL basic_release got ready=%b valid=%b exp 1/0", s_in_ready, s_out_valid);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        small_start(6'd63, 4'd0);
        small_wait(lat);
        checks += 4;
        if (lat != 1) begin failures++; $display("FAIL dz_latency got=%0d exp=1", lat); end
        if (s_quotient !== 6'd63) begin failures++; $display("FAIL dz_quotient got=%0d exp=63", s_quotient); end
        if (s_remain !== 4'd15) begin failures++; $display("FAIL dz_remain got=%0d exp=15", s_remain); end
        if (s_dbz !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", s_dbz); end
        small_release();
    endtask

    task automatic test_hold();
        int lat;
        int bad = 0;
        small_start(6'd5, 4'd12);
        small_wait(lat);
        checks += 3;
        if (lat != S_NW) begin failures++; $display("FAIL hold_latency got=%0d exp=%0d", lat, S_NW); end
        if (s_quotient !== 6'd0 || s_remain !== 4'd5) begin
            failures++; $display("FAIL hold_result got q=%0d r=%0d exp q=0 r=5", s_quotient, s_remain);
        end
        // A competing operand offered while DONE must not disturb the held result.
        s_in_valid = 1'b1;
        s_numer    = 6'd33;
        s_denom    = 4'd2;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_out_valid !== 1'b1 || s_quotient !== 6'd0 || s_remain !== 4'd5 || s_dbz !== 1'b0) bad++;
        end
        s_in_valid = 1'b0;
        if (bad != 0) begin failures++; $display("FAIL hold_stable got %0d unstable cycles exp 0", bad); end
        small_release();
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            failures++; $display("FAIL hold_release got ready=%b valid=%b exp 1/0", s_in_ready, s_out_valid);
        end
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        small_start(6'd60, 4'd7);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_quotient !== '0 || s_remain !== '0 || s_dbz !== 1'b0) begin
            failures++;
            $display("FAIL midreset got ready=%b valid=%b q=%0d r=%0d dz=%b exp 1/0/0/0/0",
                     s_in_ready, s_out_valid, s_quotient, s_remain, s_dbz);
        end
        reset = 1'b0;
        tick();
        small_start(6'd60, 4'd7);
        small_wait(lat);
        checks++;
        if (lat != S_NW || s_quotient !== 6'd8 || s_remain !== 4'd4) begin
            failures++; $display("FAIL midreset_redo got lat=%0d q=%0d r=%0d exp lat=6 q=8 r=4", lat, s_quotient, s_remain);
        end
        small_release();
    endtask

    // One wide operation checked against plain / and %; optionally jiggles in_valid while busy.
    task automatic wide_op(input logic [W_NW-1:0] n, input logic [W_DW-1:0] d, input bit poke);
        int lat = 0;
        int exp_lat;
        int busy_bad = 0;
        logic [W_NW-1:0] exp_q, prev_q;
        logic [W_DW-1:0] exp_r, prev_r;
        bit exp_dz;
        if (d == 0) begin
            exp_q = '1; exp_r = n[W_DW-1:0]; exp_dz = 1'b1; exp_lat = 1;
        end else begin
            exp_q = n / W_NW'(d); exp_r = W_DW'(n % W_NW'(d)); exp_dz = 1'b0; exp_lat = W_NW;
        end
        prev_q = w_quotient;
        prev_r = w_remain;
        w_in_valid = 1'b1;
        w_numer    = n;
        w_denom    = d;
        tick();
        w_in_valid = 1'b0;
        while (lat < 40) begin
            tick();
            lat++;
            if (w_out_valid === 1'b1) break;
            if (w_quotient !== prev_q || w_remain !== prev_r) busy_bad++;
            if (poke) begin
                w_in_valid = 1'($urandom);
                w_numer    = W_NW'($urandom);
                w_denom    = W_DW'($urandom);
            end
        end
        w_in_valid = 1'b0;
        checks++;
        if (lat != exp_lat || busy_bad != 0 || w_quotient !== exp_q || w_remain !== exp_r || w_dbz !== exp_dz) begin
            failures++;
            $display("FAIL wide n=%0d d=%0d got lat=%0d q=%0d r=%0d dz=%b busychg=%0d exp lat=%0d q=%0d r=%0d dz=%b",
                     n, d, lat, w_quotient, w_remain, w_dbz, busy_bad, exp_lat, exp_q, exp_r, exp_dz);
        end
        repeat ($urandom_range(0, 3)) tick();
        w_out_ready = 1'b1;
        tick();
        w_out_ready = 1'b0;
        checks++;
        if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0) begin
            failures++; $display("FAIL wide_release got ready=%b valid=%b exp 1/0", w_in_ready, w_out_valid);
        end
    endtask

    task automatic test_random_wide();
        logic [W_NW-1:0] n;
        logic [W_DW-1:0] d;
        wide_op(16'hFFFF, 8'd1, 1'b0);
        wide_op(16'hFFFF, 8'd255, 1'b0);
        wide_op(16'd200, 8'd255, 1'b1);
        wide_op(16'd12345, 8'd0, 1'b0);
        wide_op(16'd0, 8'd7, 1'b1);
        for (int i = 0; i < 300; i++) begin
            n = W_NW'($urandom);
            case ($urandom_range(0, 7))
                0:       d = 8'd1;
                1:       d = 8'd255;
                2:       d = 8'd0;
                3:       d = W_DW'($urandom_range(2, 15));
                default: d = W_DW'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) n = '1;
            wide_op(n, d, 1'($urandom));
        end
    endtask

    task automatic test_random_small();
        int lat;
        logic [S_NW-1:0] n;
        logic [S_DW-1:0] d;
        for (int i = 0; i < 40; i++) begin
            n = S_NW'($urandom);
            d = S_DW'($urandom_range(1, 15));
            small_start(n, d);
            small_wait(lat);
            checks++;
            if (lat != S_NW || s_quotient !== S_NW'(n / S_NW'(d)) || s_remain !== S_DW'(n % S_NW'(d)) || s_dbz !== 1'b0) begin
                failures++;
                $display("FAIL small_rand n=%0d d=%0d got lat=%0d q=%0d r=%0d exp lat=%0d q=%0d r=%0d",
                         n, d, lat, s_quotient, s_remain, S_NW, n / S_NW'(d), n % S_NW'(d));
            end
            small_release();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_hold();
        test_reset_mid_busy();
        test_random_small();
        test_random_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
